alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_issue_stage_if.sv | 48 ++++
 rtl/alu_skid_buffer.sv | 121 ++++++++++++
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: op encodings, RV32I opcode/funct constants,
// and the issue bundle passed from decode to the execute stage.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t         op;
    logic            sign;
    logic            negate;
    logic            add_one;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            is_branch;
    logic            invert;
    logic            illegal;
  } alu_issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage handshake bundle: decoded-register beat in, ALU control out.
// master = surrounding pipeline, slave = the issue stage.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_rs1_data;
  logic [WIDTH-1:0] in_rs2_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_alu_op;
  logic             out_alu_sign;
  logic             out_alu_b_negate;
  logic             out_alu_b_add_one;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_is_branch;
  logic             out_branch_invert;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_pc,
    output in_rs1_data, in_rs2_data,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_alu_op, out_alu_sign,
    input  out_alu_b_negate, out_alu_b_add_one,
    input  out_a, out_b,
    input  out_is_branch, out_branch_invert,
    input  out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  in_rs1_data, in_rs2_data,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_alu_op, out_alu_sign,
    output out_alu_b_negate, out_alu_b_add_one,
    output out_a, out_b,
    output out_is_branch, out_branch_invert,
    output out_illegal
  );
endinterface

// File: rtl/alu_skid_buffer.sv
// Output buffer for the issue stage; ALU_ISSUE_SKID_EN selects a 2-entry
// skid buffer with registered ready, otherwise a single output register.
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

`ifdef ALU_ISSUE_SKID_EN
  buf_state_t r_state;
  buf_state_t w_next;
  T           r_main;
  T           r_skid;
  logic       r_ready;
  logic       w_acc;
  logic       w_drain;
  logic       w_ld_main;
  logic       w_ld_skid;
  logic       w_pop;

  assign w_acc   = i_valid & r_ready & ~i_flush;
  assign w_drain = (r_state != BUF_EMPTY) & i_ready;

  always_comb begin
    w_next    = r_state;
    w_ld_main = 1'b0;
    w_ld_skid = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      BUF_EMPTY: begin
        if (w_acc) begin
          w_next    = BUF_ONE;
          w_ld_main = 1'b1;
        end
      end
      BUF_ONE: begin
        if (w_acc & w_drain) begin
          w_ld_main = 1'b1;
        end else if (w_acc) begin
          w_next    = BUF_TWO;
          w_ld_skid = 1'b1;
        end else if (w_drain) begin
          w_next = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (w_drain) begin
          w_next = BUF_ONE;
          w_pop  = 1'b1;
        end
      end
      default: w_next = BUF_EMPTY;
    endcase
    // flush wins over any accept or drain
    if (i_flush) begin
      w_next    = BUF_EMPTY;
      w_ld_main = 1'b0;
      w_ld_skid = 1'b0;
      w_pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != BUF_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main) r_main <= i_data;
      else if (w_pop) r_main <= r_skid;
      if (w_ld_skid) r_skid <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_state != BUF_EMPTY);
  assign o_data  = r_main;
`else
  logic r_valid;
  T     r_main;
  logic w_acc;

  assign o_ready = ~r_valid | i_ready;
  assign w_acc   = i_valid & o_ready & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_main  <= '0;
    end else begin
      if (i_flush) r_valid <= 1'b0;
      else if (w_acc) r_valid <= 1'b1;
      else if (i_ready) r_valid <= 1'b0;
      if (w_acc) r_main <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_main;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes a beat into ALU controls and operands.
// Define ALU_ISSUE_SKID_EN for the 2-entry skid buffer on the output.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic clk,
  input logic rst_n,
  alu_issue_stage_if.slave bus
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_sh_rs2;
  logic [XLEN-1:0] w_sh_imm;
  logic            w_shift;
  logic            w_is_op;
  logic            w_is_imm;
  logic            w_is_lui;
  logic            w_is_auipc;
  logic            w_is_br;
  logic            w_legal;
  logic            w_unused;
  alu_issue_t      w_d;
  alu_issue_t      w_q;

  assign w_opc    = bus.in_instr[6:0];
  assign w_f3     = bus.in_instr[14:12];
  assign w_f7     = bus.in_instr[31:25];
  assign w_rs1    = XLEN'(bus.in_rs1_data);
  assign w_rs2    = XLEN'(bus.in_rs2_data);
  assign w_pc     = XLEN'(bus.in_pc);
  assign w_imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign w_imm_u  = {bus.in_instr[31:12], 12'b0};
  assign w_sh_rs2 = XLEN'(bus.in_rs2_data[4:0]);
  assign w_sh_imm = XLEN'(bus.in_instr[24:20]);
  assign w_shift  = (w_f3 == F3_SLL) | (w_f3 == F3_SR);
  assign w_unused = ^bus.in_instr[11:7];

  assign w_is_op    = (w_opc == OPC_OP);
  assign w_is_imm   = (w_opc == OPC_OP_IMM);
  assign w_is_lui   = (w_opc == OPC_LUI);
  assign w_is_auipc = (w_opc == OPC_AUIPC);
  assign w_is_br    = (w_opc == OPC_BRANCH);

  // funct3 of OP/OP-IMM maps straight onto the ALU op encoding
  always_comb begin
    w_d     = '0;
    w_legal = 1'b1;
    unique case (1'b1)
      w_is_op: begin
        w_d.op      = alu_op_t'(w_f3);
        w_d.a       = w_rs1;
        w_d.b       = w_shift ? w_sh_rs2 : w_rs2;
        w_d.sign    = w_f7[5] & (w_f3 == F3_SR);
        w_d.negate  = w_f7[5] & (w_f3 == F3_ADD);
        w_d.add_one = w_f7[5] & (w_f3 == F3_ADD);
        w_legal     = (w_f7 == F7_BASE) |
                      ((w_f7 == F7_ALT) &
                       ((w_f3 == F3_ADD) | (w_f3 == F3_SR)));
      end
      w_is_imm: begin
        w_d.op   = alu_op_t'(w_f3);
        w_d.a    = w_rs1;
        w_d.b    = w_shift ? w_sh_imm : w_imm_i;
        w_d.sign = (w_f3 == F3_SR) & bus.in_instr[30];
        if (w_f3 == F3_SLL)
          w_legal = (w_f7 == F7_BASE);
        else if (w_f3 == F3_SR)
          w_legal = (w_f7 == F7_BASE) | (w_f7 == F7_ALT);
      end
      w_is_lui: begin
        w_d.op = ALU_ADD;
        w_d.b  = w_imm_u;
      end
      w_is_auipc: begin
        w_d.op = ALU_ADD;
        w_d.a  = w_pc;
        w_d.b  = w_imm_u;
      end
      w_is_br: begin
        w_d.a         = w_rs1;
        w_d.b         = w_rs2;
        w_d.is_branch = 1'b1;
        w_d.invert    = w_f3[0];
        case (w_f3)
          F3_BEQ, F3_BNE: begin
            w_d.op      = ALU_ADD;
            w_d.negate  = 1'b1;
            w_d.add_one = 1'b1;
          end
          F3_BLT, F3_BGE:   w_d.op = ALU_SLT;
          F3_BLTU, F3_BGEU: w_d.op = ALU_SLTU;
          default:          w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_d         = '0;
      w_d.illegal = 1'b1;
    end
  end

  alu_skid_buffer #(
    .T(alu_issue_t)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  (w_d),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_q)
  );

  assign bus.out_alu_op        = w_q.op;
  assign bus.out_alu_sign      = w_q.sign;
  assign bus.out_alu_b_negate  = w_q.negate;
  assign bus.out_alu_b_add_one = w_q.add_one;
  assign bus.out_a             = WIDTH'(w_q.a);
  assign bus.out_b             = WIDTH'(w_q.b);
  assign bus.out_is_branch     = w_q.is_branch;
  assign bus.out_branch_invert = w_q.invert;
  assign bus.out_illegal       = w_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall, flush, reset.
// Stall/flush expectations follow ALU_ISSUE_SKID_EN when it is defined.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(32)) bus ();

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [8:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vt[$];

  localparam logic [31:0] ADDI0 = 32'h0000_8093;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctrl();
    return {bus.out_alu_op, bus.out_alu_sign,
            bus.out_alu_b_negate, bus.out_alu_b_add_one,
            bus.out_is_branch, bus.out_branch_invert,
            bus.out_illegal};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2);
    bus.in_valid    = v;
    bus.in_instr    = ins;
    bus.in_pc       = pc;
    bus.in_rs1_data = r1;
    bus.in_rs2_data = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ctrl = {op[2:0], sign, negate, add_one, is_branch, invert, illegal}
    vt.push_back('{32'h402081B3, 0, 10, 3, 9'b000011000, 10, 3});
    vt.push_back('{32'h40415093, 0, 32'h80000000, 0, 9'b101100000,
                   32'h80000000, 4});
    vt.push_back('{32'h003110B3, 0, 32'h11, 32'h25, 9'b001000000,
                   32'h11, 5});
    vt.push_back('{32'h0020F063, 0, 1, 2, 9'b011000110, 1, 2});
    vt.push_back('{32'h12345097, 32'h100, 32'h55, 0, 9'b000000000,
                   32'h100, 32'h12345000});
    vt.push_back('{32'hFFF10093, 0, 5, 0, 9'b000000000,
                   5, 32'hFFFFFFFF});
    vt.push_back('{32'h00000000, 0, 7, 9, 9'b000000001, 0, 0});
    vt.push_back('{32'h40411093, 0, 3, 0, 9'b000000001, 0, 0});
    vt.push_back('{32'hABCDE0B7, 32'h200, 32'h33, 0, 9'b000000000,
                   0, 32'hABCDE000});
    vt.push_back('{32'h00209063, 0, 7, 7, 9'b000011110, 7, 7});
    vt.push_back('{32'h4020D0B3, 0, 32'hF0000000, 32'h24, 9'b101100000,
                   32'hF0000000, 4});
    vt.push_back('{32'h0020A063, 0, 1, 2, 9'b000000001, 0, 0});
    vt.push_back('{32'h0020B0B3, 0, 3, 32'hFFFFFFFF, 9'b011000000,
                   3, 32'hFFFFFFFF});
    vt.push_back('{32'h402090B3, 0, 3, 4, 9'b000000001, 0, 0});

    drive(0, 0, 0, 0, 0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_a", bus.out_a, 0);
    check("rst_b", bus.out_b, 0);
    check("rst_ctrl", ctrl(), 0);
    rst_n = 1'b1;

    // back-to-back decode stream, one beat out per cycle
    bus.out_ready = 1'b1;
    foreach (vt[i]) begin
      drive(1, vt[i].instr, vt[i].pc, vt[i].rs1, vt[i].rs2);
      tick();
      check($sformatf("v%0d_valid", i), bus.out_valid, 1);
      check($sformatf("v%0d_ctrl", i), ctrl(), vt[i].ctrl);
      check($sformatf("v%0d_a", i), bus.out_a, vt[i].a);
      check($sformatf("v%0d_b", i), bus.out_b, vt[i].b);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check("stream_empty", bus.out_valid, 0);

    // stall with three beats offered
    bus.out_ready = 1'b0;
    drive(1, ADDI0, 0, 32'hA, 0);
    #1;
    check("stall_rdy0", bus.in_ready, 1);
    tick();
    check("stall_v0", bus.out_valid, 1);
    check("stall_a0", bus.out_a, 32'hA);
`ifdef ALU_ISSUE_SKID_EN
    check("stall_rdy1", bus.in_ready, 1);
    drive(1, ADDI0, 0, 32'hB, 0);
    tick();
    check("stall_rdy2", bus.in_ready, 0);
    check("stall_hold1", bus.out_a, 32'hA);
    drive(1, ADDI0, 0, 32'hC, 0);
    tick();
    check("stall_rdy3", bus.in_ready, 0);
    check("stall_hold2", bus.out_a, 32'hA);
    bus.out_ready = 1'b1;
    tick();
    check("rel_a1", bus.out_a, 32'hB);
    check("rel_rdy", bus.in_ready, 1);
    tick();
    check("rel_a2", bus.out_a, 32'hC);
`else
    check("stall_rdy1", bus.in_ready, 0);
    drive(1, ADDI0, 0, 32'hB, 0);
    tick();
    check("stall_hold1", bus.out_a, 32'hA);
    check("stall_v1", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    #1;
    check("rel_rdy", bus.in_ready, 1);
    tick();
    check("rel_a1", bus.out_a, 32'hB);
    drive(1, ADDI0, 0, 32'hC, 0);
    tick();
    check("rel_a2", bus.out_a, 32'hC);
`endif
    drive(0, 0, 0, 0, 0);
    tick();
    check("rel_empty", bus.out_valid, 0);

    // flush while full, with a beat offered in the same cycle
    bus.out_ready = 1'b0;
    drive(1, ADDI0, 0, 32'h1, 0);
    tick();
`ifdef ALU_ISSUE_SKID_EN
    drive(1, ADDI0, 0, 32'h2, 0);
    tick();
    check("fl_full", bus.in_ready, 0);
`endif
    drive(1, ADDI0, 0, 32'hD, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("fl_valid", bus.out_valid, 0);
    check("fl_rdy", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    check("fl_gone1", bus.out_valid, 0);
    tick();
    check("fl_gone2", bus.out_valid, 0);
    drive(1, ADDI0, 0, 32'hE, 0);
    tick();
    check("fl_after", bus.out_a, 32'hE);
    drive(0, 0, 0, 0, 0);
    tick();

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    drive(1, ADDI0, 0, 32'h5, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("ar_pre", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_rdy", bus.in_ready, 1);
    check("ar_a", bus.out_a, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("ar_stay", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    drive(1, ADDI0, 0, 32'h77, 0);
    tick();
    check("ar_resume", bus.out_a, 32'h77);
    drive(0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
